// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared select encodings and shadow-stage record for hazard_fwd_unit.
package mips_hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_info_t;
endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: per-operand match/priority logic against the EX and MEM shadow stages.
module fwd_operand_sel
  import mips_hazard_pkg::*;
(
  input  stage_info_t      ex,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  output fwd_sel_t         sel,
  output logic             load_hit
);
  logic ex_hit, mem_hit;
  assign ex_hit   = uses & ex.valid & ex.regwrite & (ex.rd != REG_ZERO) & (ex.rd == src);
  assign mem_hit  = uses & mem_valid & mem_regwrite & (mem_rd != REG_ZERO) & (mem_rd == src);
  assign sel      = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_REG;
  assign load_hit = ex_hit & ex.memread;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding selects and load-use stall control.
// Define HAZARD_STALL_CNT_EN to build the saturating stall_count counter.
module hazard_fwd_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   stall,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);
  stage_info_t      ex_q;
  logic             mem_valid, mem_regwrite;
  logic [REG_W-1:0] mem_rd;
  fwd_sel_t         sel_a, sel_b, a_q, b_q;
  logic             load_a, load_b;
  fwd_operand_sel u_sel_a (
    .ex(ex_q), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .src(id_rs), .uses(id_uses_rs), .sel(sel_a), .load_hit(load_a)
  );
  fwd_operand_sel u_sel_b (
    .ex(ex_q), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .src(id_rt), .uses(id_uses_rt), .sel(sel_b), .load_hit(load_b)
  );
  assign stall         = id_valid & ~flush & (load_a | load_b);
  assign pc_write_en   = ~stall;
  assign ifid_write_en = ~stall;
  assign idex_bubble   = stall | flush;
  assign fwd_a_sel     = a_q;
  assign fwd_b_sel     = b_q;
  // Selects travel with the instruction into EX; a bubble always reads the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      a_q          <= FWD_REG;
      b_q          <= FWD_REG;
    end else begin
      mem_valid    <= ex_q.valid;
      mem_rd       <= ex_q.rd;
      mem_regwrite <= ex_q.regwrite;
      ex_q         <= (id_valid & ~idex_bubble)
                      ? stage_info_t'{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread}
                      : '0;
      a_q          <= idex_bubble ? FWD_REG : sel_a;
      b_q          <= idex_bubble ? FWD_REG : sel_b;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif
endmodule
